calc2_port_driver: RTL and testbench
====================================

Name: calc2_port_driver

Overview:
- Synthesizable request-side driver for one CALC2 port; sits directly upstream of the calc2 request inputs and consumes that port's response outputs. The bench instantiates one per port (1..4).
- Accepts operations over a valid/ready interface and allocates a free 2-bit tag for each.
- Drives the two-cycle CALC2 command protocol: cmd + operand1, then operand2 with cmd = 0.
- Tracks outstanding tags, matches responses to them, and emits one completion record per response.

Parameters:
- TAG_W, 2, tag width; table depth is 2**TAG_W = 4.
- TIMEOUT_CYCLES, 64, age at which an outstanding tag is declared lost.
- LAT_W, 8, completion latency counter width; saturates at all-ones.

Ports:
- c_clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  operation offered.
- op_ready  out  1  operation accepted when op_valid & op_ready.
- op_cmd  in  4  CALC2 command.
- op_data1  in  32  operand 1.
- op_data2  in  32  operand 2.
- req_cmd_in  out  4  to DUT reqN_cmd_in.
- req_data_in  out  32  to DUT reqN_data_in.
- req_tag_in  out  2  to DUT reqN_tag_in.
- resp_out  in  2  from DUT out_respN.
- data_out  in  32  from DUT out_dataN.
- tag_out  in  2  from DUT out_tagN.
- cpl_valid  out  1  one-cycle completion pulse.
- cpl_cmd  out  4  completion command.
- cpl_resp  out  2  completion response code.
- cpl_data  out  32  completion result data.
- cpl_tag  out  2  completion tag.
- cpl_latency  out  LAT_W  cycles from the command cycle to the response cycle.
- cpl_spurious  out  1  response received with no matching outstanding tag.
- timeout_err  out  1  one-cycle pulse when a tag times out.
- timeout_tag  out  2  tag that timed out.
- outstanding  out  3  number of outstanding tags, 0..4.

Behaviour:
- Clocking and reset: c_clk only; reset is synchronous and active-high. During reset and on the edge it is sampled:
  - all outputs go to 0 and op_ready is 0;
  - the tag table is cleared and the FSM returns to IDLE;
  - responses arriving while reset is high are ignored.
- FSM states:
  - IDLE: on accept → CMD.
  - CMD: req_cmd_in = cmd, req_data_in = data1, req_tag_in = tag; always → DATA2.
  - DATA2: req_cmd_in = 0, req_data_in = data2; on accept → CMD, otherwise → IDLE.
  - In IDLE, req_* = 0.
- All req_* outputs are registered. Accept on cycle N ⇒ cmd on N+1, data2 on N+2.
- op_ready = (state ∈ {IDLE, DATA2}) & free tag exists & !reset. Maximum issue rate is one operation per 2 cycles.
- Tag allocation: lowest-index free tag, chosen on the accept cycle. A tag freed by a response in cycle K is allocatable from K+1 onward.
- op_cmd = 0 is accepted and discarded: no bus activity, no tag allocated.
- Table entry per tag: busy, cmd, age.
  - age resets to 0 in the CMD cycle and increments each cycle while busy, saturating.
- Response handling (resp_out != 0 in cycle K):
  - tag_out busy ⇒ in K+1: cpl_valid = 1, with cmd from the table, cpl_resp = resp_out, cpl_data = data_out, cpl_tag = tag_out, cpl_latency = age. The tag is freed.
  - tag_out not busy ⇒ in K+1: cpl_spurious = 1, cpl_valid = 0, table unchanged.
- Completions have no backpressure; the cpl_* fields are valid only while cpl_valid is 1.
- Simultaneous events:
  - Accept and response in the same cycle are both processed; outstanding reflects both.
  - Response and timeout for the same tag in the same cycle: the response wins and no timeout is reported.
- outstanding is a registered popcount of the busy bits.

Optional Feature:
- Macro: CALC2_DRV_TIMEOUT_EN.
- Defined: when a busy tag's age reaches TIMEOUT_CYCLES, timeout_err pulses for one cycle with timeout_tag set, and the tag is freed. A later response on that tag is reported as spurious.
- Undefined: no timeout logic; timeout_err and timeout_tag are tied to 0 and tags stay busy until a response arrives.

Decomposition:
- Package calc2_drv_pkg:
  - cmd enum: NOP=0, ADD=1, SUB=2, SHL=5, SHR=6.
  - resp enum: NONE=0, OK=1, ERR=2, IERR=3.
  - tag-entry struct (busy, cmd, age).
  - FSM state enum.
- One sub-module, calc2_tag_table: busy bits, lowest-free encoder, age counters, timeout detect, lookup and free.

Test Plan:
- Reset held 3 cycles → all outputs 0 and op_ready 0; after release op_ready = 1 and outstanding = 0.
- ADD 5,7 accepted at N → N+1: cmd 1, data 5, tag 0; N+2: cmd 0, data 7. Response resp 1, data 12, tag 0 at N+6 → N+7: cpl_valid, cmd 1, resp 1, data 12, tag 0, latency 5.
- Four back-to-back ops → tags 0,1,2,3 driven on N+1,N+3,N+5,N+7; op_ready 0 with outstanding = 4. Response on tag 2 → next accept gets tag 2.
- Response resp 1, tag 3 with nothing outstanding → cpl_spurious pulses for 1 cycle, cpl_valid stays 0, outstanding stays 0.
- Macro on, TIMEOUT_CYCLES = 16: SUB with no response → timeout_err with timeout_tag 0 16 cycles after the CMD cycle, outstanding returns to 0. A later response on tag 0 → cpl_spurious.
- Reset asserted during DATA2 → next edge: req_* = 0, table empty, no cpl_valid. A response arriving then → cpl_spurious.

Source files
------------

// File: rtl/calc2_drv_pkg.sv
// Shared types and constants for the CALC2 port driver.
// The optional tag-timeout feature is controlled by CALC2_DRV_TIMEOUT_EN.
package calc2_drv_pkg;

  localparam int TAG_W = 2;
  localparam int DEPTH = 1 << TAG_W;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AGE_W = 8;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2,
    RESP_IERR = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_DATA2 = 2'd2
  } state_e;

  // cmd is kept as raw bits so unlisted command codes round-trip untouched
  typedef struct packed {
    logic             busy;
    logic [3:0]       cmd;
    logic [AGE_W-1:0] age;
  } tag_entry_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/calc2_port_driver_tag_table.sv
// Outstanding-tag table: busy bits, lowest-free allocation, per-tag age,
// response lookup/free and (with CALC2_DRV_TIMEOUT_EN) timeout detection.
module calc2_tag_table
  import calc2_drv_pkg::*;
`ifdef CALC2_DRV_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 64
)
`endif
(
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc,
  input  logic [3:0]       alloc_cmd,
  input  logic             resp_valid,
  input  logic [TAG_W-1:0] resp_tag,
  output logic             free_avail,
  output logic [TAG_W-1:0] free_tag,
  output logic             hit,
  output logic [3:0]       hit_cmd,
  output logic [AGE_W-1:0] hit_age,
  output logic             timeout_err,
  output logic [TAG_W-1:0] timeout_tag,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] busy_vec;
  logic [DEPTH-1:0] alloc_vec;
  logic [DEPTH-1:0] release_vec;
  logic [DEPTH-1:0] busy_next;
  logic [3:0]       cmd_arr [DEPTH];
  logic [AGE_W-1:0] age_arr [DEPTH];
  logic             to_fire;
  logic [TAG_W-1:0] to_idx;
  logic [CNT_W-1:0] count_reg;

  // Lowest-index free tag; scanning downward leaves the smallest index last
  always_comb begin
    free_avail = 1'b0;
    free_tag   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_vec[i]) begin
        free_avail = 1'b1;
        free_tag   = TAG_W'(i);
      end
    end
  end

  assign hit     = resp_valid & busy_vec[resp_tag];
  assign hit_cmd = cmd_arr[resp_tag];
  assign hit_age = age_arr[resp_tag];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      tag_entry_t entry_reg;

      assign alloc_vec[gi]   = alloc & free_avail & (free_tag == TAG_W'(gi));
      assign release_vec[gi] = (hit & (resp_tag == TAG_W'(gi))) |
                               (to_fire & (to_idx == TAG_W'(gi)));
      assign busy_next[gi]   = (entry_reg.busy | alloc_vec[gi]) & ~release_vec[gi];
      assign busy_vec[gi]    = entry_reg.busy;
      assign cmd_arr[gi]     = entry_reg.cmd;
      assign age_arr[gi]     = entry_reg.age;

      // Allocation zeroes the age so it reads 0 in the command cycle
      always_ff @(posedge clk) begin
        if (reset) begin
          entry_reg <= '0;
        end else if (alloc_vec[gi]) begin
          entry_reg.busy <= 1'b1;
          entry_reg.cmd  <= alloc_cmd;
          entry_reg.age  <= '0;
        end else if (release_vec[gi]) begin
          entry_reg.busy <= 1'b0;
        end else if (entry_reg.busy && entry_reg.age != '1) begin
          entry_reg.age <= entry_reg.age + 1'b1;
        end
      end
    end
  endgenerate

`ifdef CALC2_DRV_TIMEOUT_EN
  // Fire one cycle early so the pulse lands TIMEOUT_CYCLES after the command
  localparam logic [AGE_W-1:0] TO_AGE = AGE_W'(TIMEOUT_CYCLES - 1);
  logic             to_err_reg;
  logic [TAG_W-1:0] to_tag_reg;

  // A response to the same tag in the same cycle suppresses its timeout
  always_comb begin
    to_fire = 1'b0;
    to_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (busy_vec[i] && age_arr[i] == TO_AGE &&
          !(hit && resp_tag == TAG_W'(i))) begin
        to_fire = 1'b1;
        to_idx  = TAG_W'(i);
      end
    end
  end

  // Registered one-cycle timeout pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      to_err_reg <= 1'b0;
      to_tag_reg <= '0;
    end else begin
      to_err_reg <= to_fire;
      to_tag_reg <= to_fire ? to_idx : '0;
    end
  end

  assign timeout_err = to_err_reg;
  assign timeout_tag = to_tag_reg;
`else
  assign to_fire     = 1'b0;
  assign to_idx      = '0;
  assign timeout_err = 1'b0;
  assign timeout_tag = '0;
`endif

  // Count tracks the post-edge busy set, so it reflects same-cycle alloc/free
  always_ff @(posedge clk) begin
    if (reset) count_reg <= '0;
    else       count_reg <= popcount(busy_next);
  end

  assign count = count_reg;

endmodule

// File: rtl/calc2_port_driver.sv
// Request-side driver for one CALC2 port: accepts operations, allocates tags,
// drives the two-cycle command protocol and reports completions.
// Tag timeouts exist only when CALC2_DRV_TIMEOUT_EN is defined.
module calc2_port_driver
  import calc2_drv_pkg::*;
#(
`ifdef CALC2_DRV_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 64,
`endif
  parameter int LAT_W = 8
)(
  input  logic             c_clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_cmd,
  input  logic [31:0]      op_data1,
  input  logic [31:0]      op_data2,
  output logic [3:0]       req_cmd_in,
  output logic [31:0]      req_data_in,
  output logic [TAG_W-1:0] req_tag_in,
  input  logic [1:0]       resp_out,
  input  logic [31:0]      data_out,
  input  logic [TAG_W-1:0] tag_out,
  output logic             cpl_valid,
  output logic [3:0]       cpl_cmd,
  output logic [1:0]       cpl_resp,
  output logic [31:0]      cpl_data,
  output logic [TAG_W-1:0] cpl_tag,
  output logic [LAT_W-1:0] cpl_latency,
  output logic             cpl_spurious,
  output logic             timeout_err,
  output logic [TAG_W-1:0] timeout_tag,
  output logic [CNT_W-1:0] outstanding
);

  state_e           state_reg;
  logic [3:0]       req_cmd_reg;
  logic [31:0]      req_data_reg;
  logic [TAG_W-1:0] req_tag_reg;
  logic [31:0]      data2_reg;
  logic             cpl_valid_reg;
  logic             cpl_spurious_reg;
  logic [3:0]       cpl_cmd_reg;
  logic [1:0]       cpl_resp_reg;
  logic [31:0]      cpl_data_reg;
  logic [TAG_W-1:0] cpl_tag_reg;
  logic [LAT_W-1:0] cpl_latency_reg;

  logic             free_avail;
  logic [TAG_W-1:0] free_tag;
  logic             hit;
  logic [3:0]       hit_cmd;
  logic [AGE_W-1:0] hit_age;
  logic             accept;
  logic             resp_valid;

  // A NOP handshakes normally but starts no bus activity and takes no tag
  assign op_ready   = (state_reg != ST_CMD) & free_avail & ~reset;
  assign accept     = op_valid & op_ready & (op_cmd != CMD_NOP);
  assign resp_valid = (resp_out != RESP_NONE) & ~reset;

  calc2_tag_table
`ifdef CALC2_DRV_TIMEOUT_EN
    #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES))
`endif
    u_table (
      .clk         (c_clk),
      .reset       (reset),
      .alloc       (accept),
      .alloc_cmd   (op_cmd),
      .resp_valid  (resp_valid),
      .resp_tag    (tag_out),
      .free_avail  (free_avail),
      .free_tag    (free_tag),
      .hit         (hit),
      .hit_cmd     (hit_cmd),
      .hit_age     (hit_age),
      .timeout_err (timeout_err),
      .timeout_tag (timeout_tag),
      .count       (outstanding)
    );

  // Command FSM; state names the phase currently shown on the req_* bus
  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      req_cmd_reg  <= '0;
      req_data_reg <= '0;
      req_tag_reg  <= '0;
      data2_reg    <= '0;
    end else begin
      case (state_reg)
        ST_CMD: begin
          req_cmd_reg  <= '0;
          req_data_reg <= data2_reg;
          state_reg    <= ST_DATA2;
        end
        default: begin
          if (accept) begin
            req_cmd_reg  <= op_cmd;
            req_data_reg <= op_data1;
            req_tag_reg  <= free_tag;
            data2_reg    <= op_data2;
            state_reg    <= ST_CMD;
          end else begin
            req_cmd_reg  <= '0;
            req_data_reg <= '0;
            req_tag_reg  <= '0;
            state_reg    <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Completion record one cycle after the response; fields hold otherwise
  always_ff @(posedge c_clk) begin
    if (reset) begin
      cpl_valid_reg    <= 1'b0;
      cpl_spurious_reg <= 1'b0;
      cpl_cmd_reg      <= '0;
      cpl_resp_reg     <= '0;
      cpl_data_reg     <= '0;
      cpl_tag_reg      <= '0;
      cpl_latency_reg  <= '0;
    end else begin
      cpl_valid_reg    <= hit;
      cpl_spurious_reg <= resp_valid & ~hit;
      if (hit) begin
        cpl_cmd_reg     <= hit_cmd;
        cpl_resp_reg    <= resp_out;
        cpl_data_reg    <= data_out;
        cpl_tag_reg     <= tag_out;
        cpl_latency_reg <= LAT_W'(hit_age);
      end
    end
  end

  assign req_cmd_in   = req_cmd_reg;
  assign req_data_in  = req_data_reg;
  assign req_tag_in   = req_tag_reg;
  assign cpl_valid    = cpl_valid_reg;
  assign cpl_spurious = cpl_spurious_reg;
  assign cpl_cmd      = cpl_cmd_reg;
  assign cpl_resp     = cpl_resp_reg;
  assign cpl_data     = cpl_data_reg;
  assign cpl_tag      = cpl_tag_reg;
  assign cpl_latency  = cpl_latency_reg;

endmodule

// File: tb/tb_calc2_port_driver.sv
// Scoreboard bench for calc2_port_driver; timeout section active only with
// CALC2_DRV_TIMEOUT_EN (TIMEOUT_CYCLES overridden to 16).
module tb_calc2_port_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_cmd;
  logic [31:0] op_data1;
  logic [31:0] op_data2;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0]  req_tag_in;
  logic [1:0]  resp_out;
  logic [31:0] data_out;
  logic [1:0]  tag_out;
  logic        cpl_valid;
  logic [3:0]  cpl_cmd;
  logic [1:0]  cpl_resp;
  logic [31:0] cpl_data;
  logic [1:0]  cpl_tag;
  logic [7:0]  cpl_latency;
  logic        cpl_spurious;
  logic        timeout_err;
  logic [1:0]  timeout_tag;
  logic [2:0]  outstanding;

  typedef struct packed {
    logic        spur;
    logic [3:0]  cmd;
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
    logic [7:0]  lat;
  } exp_t;

  exp_t       cpl_q[$];
  logic [1:0] to_q[$];
  exp_t       mon_e;
  logic [1:0] mon_t;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  calc2_port_driver #(
`ifdef CALC2_DRV_TIMEOUT_EN
    .TIMEOUT_CYCLES(16),
`endif
    .LAT_W(8)
  ) dut (
    .c_clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_cmd(op_cmd), .op_data1(op_data1), .op_data2(op_data2),
    .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .resp_out(resp_out), .data_out(data_out), .tag_out(tag_out),
    .cpl_valid(cpl_valid), .cpl_cmd(cpl_cmd), .cpl_resp(cpl_resp),
    .cpl_data(cpl_data), .cpl_tag(cpl_tag), .cpl_latency(cpl_latency),
    .cpl_spurious(cpl_spurious), .timeout_err(timeout_err),
    .timeout_tag(timeout_tag), .outstanding(outstanding)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cpl(input logic spur, input logic [3:0] cmd, input logic [1:0] resp,
                          input logic [31:0] data, input logic [1:0] tag, input logic [7:0] lat);
    exp_t e;
    e.spur = spur; e.cmd = cmd; e.resp = resp; e.data = data; e.tag = tag; e.lat = lat;
    cpl_q.push_back(e);
  endtask

  // Accept in the current cycle N, check cmd phase at N+1 and data2 at N+2
  task automatic issue(input logic [3:0] cmd, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [1:0] etag);
    op_valid = 1'b1; op_cmd = cmd; op_data1 = d1; op_data2 = d2;
    #1;
    check("op_ready_at_issue", op_ready, 1);
    tick();
    op_valid = 1'b0; op_cmd = 0; op_data1 = 0; op_data2 = 0;
    resp_out = 0; data_out = 0; tag_out = 0;
    $display("issue: cmd=%0d data1=0x%0h tag=%0d", req_cmd_in, req_data_in, req_tag_in);
    check("req_cmd_phase1", req_cmd_in, cmd);
    check("req_data_phase1", req_data_in, d1);
    check("req_tag_phase1", req_tag_in, etag);
    tick();
    check("req_cmd_phase2", req_cmd_in, 0);
    check("req_data_phase2", req_data_in, d2);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a completion or timeout
  always @(negedge clk) begin
    if (cpl_valid || cpl_spurious) begin
      $display("cpl: valid=%0b spurious=%0b cmd=%0d resp=%0d data=0x%0h tag=%0d lat=%0d",
               cpl_valid, cpl_spurious, cpl_cmd, cpl_resp, cpl_data, cpl_tag, cpl_latency);
      if (cpl_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL cpl_unexpected: got valid=%0b spurious=%0b, required no completion",
                 cpl_valid, cpl_spurious);
      end else begin
        mon_e = cpl_q.pop_front();
        check("cpl_spurious", cpl_spurious, mon_e.spur);
        check("cpl_valid", cpl_valid, !mon_e.spur);
        if (!mon_e.spur) begin
          check("cpl_cmd", cpl_cmd, mon_e.cmd);
          check("cpl_resp", cpl_resp, mon_e.resp);
          check("cpl_data", cpl_data, mon_e.data);
          check("cpl_tag", cpl_tag, mon_e.tag);
          check("cpl_latency", cpl_latency, mon_e.lat);
        end
      end
    end
    if (timeout_err) begin
      $display("timeout: tag=%0d", timeout_tag);
      if (to_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL timeout_unexpected: got tag=%0d, required no timeout", timeout_tag);
      end else begin
        mon_t = to_q.pop_front();
        check("timeout_tag", timeout_tag, mon_t);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; op_valid = 0; op_cmd = 0; op_data1 = 0; op_data2 = 0;
    resp_out = 0; data_out = 0; tag_out = 0;

    // Reset held 3 cycles
    repeat (3) tick();
    check("rst_op_ready", op_ready, 0);
    check("rst_req_cmd", req_cmd_in, 0);
    check("rst_req_data", req_data_in, 0);
    check("rst_req_tag", req_tag_in, 0);
    check("rst_cpl_valid", cpl_valid, 0);
    check("rst_cpl_spurious", cpl_spurious, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_outstanding", outstanding, 0);
    reset = 1'b0;
    tick();
    check("post_rst_op_ready", op_ready, 1);
    check("post_rst_outstanding", outstanding, 0);

    // Response with nothing outstanding
    resp_out = 2'd1; tag_out = 2'd3; data_out = 32'h55;
    push_cpl(1'b1, 0, 0, 0, 0, 0);
    tick();
    resp_out = 0; tag_out = 0; data_out = 0;
    check("spur_outstanding", outstanding, 0);
    tick();

    // NOP is consumed without bus activity or tag
    op_valid = 1'b1; op_cmd = 4'd0; op_data1 = 32'hFF; op_data2 = 32'hEE;
    #1;
    check("nop_op_ready", op_ready, 1);
    tick();
    op_valid = 1'b0; op_data1 = 0; op_data2 = 0;
    check("nop_req_cmd", req_cmd_in, 0);
    check("nop_req_data", req_data_in, 0);
    check("nop_outstanding", outstanding, 0);
    check("nop_still_ready", op_ready, 1);

    // ADD 5,7 at N; response at N+6 -> latency 5
    issue(4'd1, 32'd5, 32'd7, 2'd0);
    check("add_outstanding", outstanding, 1);
    tick();
    check("idle_req_cmd", req_cmd_in, 0);
    check("idle_req_data", req_data_in, 0);
    repeat (3) tick();
    resp_out = 2'd1; tag_out = 2'd0; data_out = 32'd12;
    push_cpl(1'b0, 4'd1, 2'd1, 32'd12, 2'd0, 8'd5);
    // Same-cycle accept: tag 0 still busy, so SHR gets tag 1
    issue(4'd6, 32'd3, 32'd9, 2'd1);
    check("simul_outstanding", outstanding, 1);
    resp_out = 2'd1; tag_out = 2'd1; data_out = 32'd0;
    push_cpl(1'b0, 4'd6, 2'd1, 32'd0, 2'd1, 8'd1);
    tick();
    resp_out = 0; tag_out = 0;
    check("drain_outstanding", outstanding, 0);

    // Four back-to-back operations fill the table
    issue(4'd1, 32'd1, 32'd2, 2'd0);
    issue(4'd2, 32'd3, 32'd4, 2'd1);
    issue(4'd5, 32'd5, 32'd6, 2'd2);
    issue(4'd6, 32'd7, 32'd8, 2'd3);
    op_valid = 1'b1; op_cmd = 4'd1; op_data1 = 32'd9; op_data2 = 32'd10;
    resp_out = 2'd2; tag_out = 2'd2; data_out = 32'hA0;
    push_cpl(1'b0, 4'd5, 2'd2, 32'hA0, 2'd2, 8'd3);
    #1;
    check("full_op_ready", op_ready, 0);
    check("full_outstanding", outstanding, 4);
    tick();
    resp_out = 0; tag_out = 0; data_out = 0;
    check("full_no_accept_cmd", req_cmd_in, 0);
    check("freed_outstanding", outstanding, 3);
    issue(4'd1, 32'd9, 32'd10, 2'd2);

    // Reset during DATA2; response under reset is ignored
    reset = 1'b1; resp_out = 2'd1; tag_out = 2'd0; data_out = 32'hDEAD;
    #1;
    check("rst_data2_op_ready", op_ready, 0);
    tick();
    reset = 1'b0;
    push_cpl(1'b1, 0, 0, 0, 0, 0);
    check("rst_data2_req_cmd", req_cmd_in, 0);
    check("rst_data2_req_data", req_data_in, 0);
    check("rst_data2_req_tag", req_tag_in, 0);
    check("rst_data2_outstanding", outstanding, 0);
    check("rst_data2_cpl_valid", cpl_valid, 0);
    tick();
    resp_out = 0; tag_out = 0; data_out = 0;
    check("rst_data2_after_outstanding", outstanding, 0);

    // SUB with no response
    issue(4'd2, 32'd20, 32'd6, 2'd0);
`ifdef CALC2_DRV_TIMEOUT_EN
    to_q.push_back(2'd0);
    repeat (14) tick();
    check("to_before_err", timeout_err, 0);
    check("to_before_outstanding", outstanding, 1);
    tick();
    check("to_err", timeout_err, 1);
    check("to_outstanding", outstanding, 0);
    resp_out = 2'd1; tag_out = 2'd0; data_out = 32'd14;
    push_cpl(1'b1, 0, 0, 0, 0, 0);
    tick();
    resp_out = 0; tag_out = 0; data_out = 0;
    check("to_pulse_width", timeout_err, 0);
`else
    repeat (20) tick();
    check("noto_err", timeout_err, 0);
    check("noto_outstanding", outstanding, 1);
    resp_out = 2'd1; tag_out = 2'd0; data_out = 32'd14;
    push_cpl(1'b0, 4'd2, 2'd1, 32'd14, 2'd0, 8'd21);
    tick();
    resp_out = 0; tag_out = 0; data_out = 0;
    check("noto_drain_outstanding", outstanding, 0);
`endif

    repeat (3) tick();
    check("cpl_queue_empty", cpl_q.size(), 0);
    check("timeout_queue_empty", to_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
